// File: rtl/multi_channel_up_down_counter_pkg.sv
// Shared types and constants for the AXI slave response-path counter bank.
//   cnt_mode_t : per-channel counting direction (UP, DOWN, HOLD, RSVD)
//   TRUE/FALSE : single-bit boolean constants
package axi_slave_package;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      UP   = 2'd0,
      DOWN = 2'd1,
      HOLD = 2'd2,
      RSVD = 2'd3
   } cnt_mode_t;

endpackage

// File: rtl/up_down_counter_ch.sv
// Single-channel up/down counter with runtime limit, saturate/wrap select,
// registered terminal-count pulse and sticky overflow flag.
// Ports:
//   clk, arst        : clock (rising edge), async active-low reset
//   ld, ld_val       : synchronous load (value clamped to lim)
//   lim              : runtime upper bound, legal counts are 0..lim
//   en, mode, wrap   : count enable, direction, 1 = wrap / 0 = saturate
//   ovf_clr          : clears the sticky overflow flag
//   count            : registered count
//   at_zero, at_lim  : combinational, gated by en
//   done             : one-cycle pulse when a counting step lands on the terminal value
//   ovf              : sticky wrap indicator
module up_down_counter_ch
   import axi_slave_package::*;
#(
   parameter int CNT_W          = 8,
   parameter bit DISABLE_CLEARS = TRUE
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   input  logic [CNT_W-1:0] lim,
   input  logic             en,
   input  cnt_mode_t        mode,
   input  logic             wrap,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] count,
   output logic             at_zero,
   output logic             at_lim,
   output logic             done,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic             done_r;
   logic             ovf_r;

   logic [CNT_W-1:0] next_cnt_s;
   logic [CNT_W-1:0] term_s;
   logic             step_s;
   logic             wrap_evt_s;
   logic             done_nxt_s;
   logic             ovf_nxt_s;

   // Next-count selection: load, then enabled counting, then the disabled policy.
   always_comb begin
      next_cnt_s = count_r;
      step_s     = 1'b0;
      wrap_evt_s = 1'b0;
      if (ld) begin
         next_cnt_s = (ld_val > lim) ? lim : ld_val;
      end else if (en) begin
         case (mode)
            UP: begin
               step_s = 1'b1;
               // A limit that shrank under the count pulls it straight to lim.
               if (count_r > lim) begin
                  next_cnt_s = lim;
               end else if (count_r < lim) begin
                  next_cnt_s = count_r + ONE_C;
               end else if (wrap) begin
                  next_cnt_s = ZERO_C;
                  wrap_evt_s = 1'b1;
               end else begin
                  next_cnt_s = lim;
               end
            end
            DOWN: begin
               step_s = 1'b1;
               if (count_r > lim) begin
                  next_cnt_s = lim;
               end else if (count_r > ZERO_C) begin
                  next_cnt_s = count_r - ONE_C;
               end else if (wrap) begin
                  next_cnt_s = lim;
                  wrap_evt_s = 1'b1;
               end else begin
                  next_cnt_s = ZERO_C;
               end
            end
            default: begin
               next_cnt_s = count_r;
            end
         endcase
      end else if (DISABLE_CLEARS) begin
         next_cnt_s = ZERO_C;
      end else begin
         next_cnt_s = count_r;
      end
   end

   // Terminal pulse and sticky overflow next state.
   always_comb begin
      term_s     = (mode == DOWN) ? ZERO_C : lim;
      // Pulse on arrival at the terminal value; a wrap that lands on it
      // (only possible with lim == 0) also counts as an arrival.
      done_nxt_s = step_s & (next_cnt_s == term_s) &
                   ((count_r != term_s) | wrap_evt_s);
      if (wrap_evt_s) begin
         ovf_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         count_r <= ZERO_C;
         done_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= next_cnt_s;
         done_r  <= done_nxt_s;
         ovf_r   <= ovf_nxt_s;
      end
   end

   assign count   = count_r;
   assign done    = done_r;
   assign ovf     = ovf_r;
   assign at_zero = en & (count_r == ZERO_C);
   assign at_lim  = en & (count_r == lim);

endmodule

// File: rtl/multi_channel_up_down_counter.sv
// Bank of NUM_CH independent up/down counters sharing clk/arst.
// Ports (channel i occupies bit i, or [i*CNT_W +: CNT_W], or [i*2 +: 2]):
//   clk, arst : clock, async active-low reset
//   ld, ld_val, lim, en, mode, wrap, ovf_clr : per-channel controls
//   count, at_zero, at_lim, done, ovf        : per-channel status
module multi_channel_up_down_counter
   import axi_slave_package::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 8,
   parameter bit DISABLE_CLEARS = 1'b1
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [NUM_CH-1:0]       ld,
   input  logic [NUM_CH*CNT_W-1:0] ld_val,
   input  logic [NUM_CH*CNT_W-1:0] lim,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*2-1:0]     mode,
   input  logic [NUM_CH-1:0]       wrap,
   input  logic [NUM_CH-1:0]       ovf_clr,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH-1:0]       at_zero,
   output logic [NUM_CH-1:0]       at_lim,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       ovf
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      up_down_counter_ch #(
         .CNT_W          (CNT_W),
         .DISABLE_CLEARS (DISABLE_CLEARS)
      ) u_ch (
         .clk     (clk),
         .arst    (arst),
         .ld      (ld[i]),
         .ld_val  (ld_val[i*CNT_W +: CNT_W]),
         .lim     (lim[i*CNT_W +: CNT_W]),
         .en      (en[i]),
         .mode    (cnt_mode_t'(mode[i*2 +: 2])),
         .wrap    (wrap[i]),
         .ovf_clr (ovf_clr[i]),
         .count   (count[i*CNT_W +: CNT_W]),
         .at_zero (at_zero[i]),
         .at_lim  (at_lim[i]),
         .done    (done[i]),
         .ovf     (ovf[i])
      );
   end

endmodule

// File: tb/tb_multi_channel_up_down_counter.sv
// Self-checking bench: two counter banks (clearing and holding disable
// policy) share all inputs and are compared to a behavioural model each cycle.
module tb_multi_channel_up_down_counter;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int VW     = NUM_CH*CNT_W;

   logic              clk = 1'b0;
   logic              arst;
   logic [NUM_CH-1:0] ld, en, wrap, ovf_clr;
   logic [VW-1:0]     ld_val, lim;
   logic [NUM_CH*2-1:0] mode;

   logic [VW-1:0]     count_c, count_h;
   logic [NUM_CH-1:0] az_c, al_c, done_c, ovf_c;
   logic [NUM_CH-1:0] az_h, al_h, done_h, ovf_h;

   int n_chk  = 0;
   int n_fail = 0;

   // model state: index 0 = clearing bank, 1 = holding bank
   int m_cnt  [2][NUM_CH];
   bit m_done [2][NUM_CH];
   bit m_ovf  [2][NUM_CH];

   typedef struct {
      int ch; bit ld; int ldv; int lim; bit en; int md; bit w; bit clr;
      int ec; bit ed; bit eo;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   multi_channel_up_down_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DISABLE_CLEARS(1'b1)) dut_c (
      .clk(clk), .arst(arst), .ld(ld), .ld_val(ld_val), .lim(lim), .en(en), .mode(mode),
      .wrap(wrap), .ovf_clr(ovf_clr), .count(count_c), .at_zero(az_c), .at_lim(al_c),
      .done(done_c), .ovf(ovf_c));

   multi_channel_up_down_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DISABLE_CLEARS(1'b0)) dut_h (
      .clk(clk), .arst(arst), .ld(ld), .ld_val(ld_val), .lim(lim), .en(en), .mode(mode),
      .wrap(wrap), .ovf_clr(ovf_clr), .count(count_h), .at_zero(az_h), .at_lim(al_h),
      .done(done_h), .ovf(ovf_h));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec rules in plain integer arithmetic.
   task automatic mstep(input int d, input int ch, output int nc, output bit nd, output bit no);
      int c, lm, ldv, md, t;
      bit wr, step;
      c = m_cnt[d][ch];
      lm = int'(lim[ch*CNT_W +: CNT_W]);
      ldv = int'(ld_val[ch*CNT_W +: CNT_W]);
      md = int'(mode[ch*2 +: 2]);
      wr = 0; step = 0; nc = c;
      if (ld[ch]) nc = (ldv < lm) ? ldv : lm;
      else if (en[ch]) begin
         if (md == 0) begin
            step = 1;
            if (c > lm) nc = lm;
            else if (c < lm) nc = c + 1;
            else if (wrap[ch]) begin nc = 0; wr = 1; end
            else nc = lm;
         end else if (md == 1) begin
            step = 1;
            if (c > lm) nc = lm;
            else if (c > 0) nc = c - 1;
            else if (wrap[ch]) begin nc = lm; wr = 1; end
            else nc = 0;
         end
      end else if (d == 0) nc = 0;
      t = (md == 1) ? 0 : lm;
      nd = step && (nc == t) && (c != t || wr);
      no = wr || (m_ovf[d][ch] && !ovf_clr[ch]);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[d][ch] = 0; m_done[d][ch] = 0; m_ovf[d][ch] = 0;
         end
   endtask

   task automatic check_all();
      logic [VW-1:0] ec [2];
      logic [NUM_CH-1:0] ed [2], eo [2], eaz [2], eal [2];
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < NUM_CH; ch++) begin
            ec[d][ch*CNT_W +: CNT_W] = m_cnt[d][ch][CNT_W-1:0];
            ed[d][ch]  = m_done[d][ch];
            eo[d][ch]  = m_ovf[d][ch];
            eaz[d][ch] = en[ch] && (m_cnt[d][ch] == 0);
            eal[d][ch] = en[ch] && (m_cnt[d][ch] == int'(lim[ch*CNT_W +: CNT_W]));
         end
      chk("count_clr", 64'(count_c), 64'(ec[0]));
      chk("done_clr",  64'(done_c),  64'(ed[0]));
      chk("ovf_clr",   64'(ovf_c),   64'(eo[0]));
      chk("atz_clr",   64'(az_c),    64'(eaz[0]));
      chk("atl_clr",   64'(al_c),    64'(eal[0]));
      chk("count_hld", 64'(count_h), 64'(ec[1]));
      chk("done_hld",  64'(done_h),  64'(ed[1]));
      chk("ovf_hld",   64'(ovf_h),   64'(eo[1]));
      chk("atz_hld",   64'(az_h),    64'(eaz[1]));
      chk("atl_hld",   64'(al_h),    64'(eal[1]));
   endtask

   task automatic tick();
      int nc [2][NUM_CH];
      bit nd [2][NUM_CH];
      bit no [2][NUM_CH];
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < NUM_CH; ch++)
            mstep(d, ch, nc[d][ch], nd[d][ch], no[d][ch]);
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[d][ch] = nc[d][ch]; m_done[d][ch] = nd[d][ch]; m_ovf[d][ch] = no[d][ch];
         end
      check_all();
   endtask

   task automatic set_ch(input int ch, input bit l, input int v, input int lm,
                         input bit e, input int md, input bit w, input bit c);
      ld[ch] = l; ld_val[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
      lim[ch*CNT_W +: CNT_W] = lm[CNT_W-1:0]; en[ch] = e;
      mode[ch*2 +: 2] = md[1:0]; wrap[ch] = w; ovf_clr[ch] = c;
   endtask

   task automatic idle_all();
      ld = '0; en = '0; ovf_clr = '0;
   endtask

   // Asynchronous reset asserted away from a clock edge and checked at once.
   task automatic async_reset();
      idle_all();
      #3 arst = 1'b0;
      #1;
      model_reset();
      chk("rst_count_clr", 64'(count_c), 64'd0);
      chk("rst_count_hld", 64'(count_h), 64'd0);
      chk("rst_done", 64'({done_c, done_h}), 64'd0);
      chk("rst_ovf",  64'({ovf_c, ovf_h}), 64'd0);
      @(negedge clk); @(negedge clk);
      arst = 1'b1;
   endtask

   function automatic vec_t mk(int ch, bit l, int v, int lm, bit e, int md, bit w, bit c,
                               int ec, bit ed, bit eo);
      vec_t r;
      r.ch = ch; r.ld = l; r.ldv = v; r.lim = lm; r.en = e; r.md = md; r.w = w; r.clr = c;
      r.ec = ec; r.ed = ed; r.eo = eo;
      return r;
   endfunction

   initial begin
      arst = 1'b0;
      ld = '0; en = '0; wrap = '0; ovf_clr = '0; ld_val = '0; lim = '0; mode = '0;
      model_reset();
      #12;
      chk("init_count", 64'({count_c, count_h}), 64'd0);
      chk("init_flags", 64'({done_c, ovf_c, done_h, ovf_h}), 64'd0);
      @(negedge clk); arst = 1'b1;

      // reset mid-count: ch0 at 5
      set_ch(0, 1, 3, 20, 0, 0, 0, 0); tick();
      set_ch(0, 0, 0, 20, 1, 0, 0, 0); tick(); tick();
      chk("pre_rst_count", 64'(count_c[7:0]), 64'd5);
      async_reset();
      tick();
      chk("post_rst_count", 64'(count_c[7:0]), 64'd0);
      chk("post_rst_done", 64'(done_c), 64'd0);

      // directed table
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, (k < 3) ? k + 1 : 3, k == 2, 0));
      tbl.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 2, 0, 0));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 3, 1, 0));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 2, 0, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 0, 3, 1, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(3, 1, 200, 10, 1, 1, 0, 0, 10, 0, 0));
      for (int k = 9; k >= 0; k--)
         tbl.push_back(mk(3, 0, 0, 10, 1, 1, 0, 0, k, k == 0, 0));
      tbl.push_back(mk(3, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         idle_all();
         set_ch(tbl[i].ch, tbl[i].ld, tbl[i].ldv, tbl[i].lim, tbl[i].en, tbl[i].md,
                tbl[i].w, tbl[i].clr);
         tick();
         chk($sformatf("tbl%0d_count", i), 64'(count_c[tbl[i].ch*CNT_W +: CNT_W]), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d_done", i), 64'(done_c[tbl[i].ch]), 64'(tbl[i].ed));
         chk($sformatf("tbl%0d_ovf", i), 64'(ovf_c[tbl[i].ch]), 64'(tbl[i].eo));
      end
      chk("down_at_zero", 64'(az_c[3]), 64'd1);

      // limit shrink then disable
      idle_all();
      set_ch(0, 1, 7, 20, 0, 0, 0, 0); tick();
      set_ch(0, 0, 0, 4, 1, 0, 0, 0); tick();
      chk("shrink_count_clr", 64'(count_c[7:0]), 64'd4);
      chk("shrink_count_hld", 64'(count_h[7:0]), 64'd4);
      chk("shrink_ovf", 64'({ovf_c[0], ovf_h[0]}), 64'd0);
      set_ch(0, 0, 0, 4, 0, 0, 0, 0); tick();
      chk("dis_clear", 64'(count_c[7:0]), 64'd0);
      chk("dis_hold", 64'(count_h[7:0]), 64'd4);

      // randomized, all channels concurrently
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc == 300) async_reset();
         for (int ch = 0; ch < NUM_CH; ch++) begin
            int lm;
            lm = int'(lim[ch*CNT_W +: CNT_W]);
            if ($urandom_range(0, 15) == 0)
               lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            set_ch(ch, $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)), lm,
                   $urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_channel_up_down_counter.md
Name: multi_channel_up_down_counter

Overview:
- Bank of NUM_CH independent up/down counters, each with a runtime limit, selectable saturate/wrap, and registered terminal-count and overflow reporting.
- Used by the AXI slave response path, where the push FSMs track per-ID beat and credit counts. It replaces single-channel, fixed-limit counter instances.
- All channels share clk/arst. Channels never interact.

Parameters:
- NUM_CH, 4, number of counter channels.
- CNT_W, 8, counter and limit width per channel.
- DISABLE_CLEARS, 1, en low with ld low: 1 = count cleared to 0, 0 = count held.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous, active-low reset.
- ld  in  NUM_CH  per-channel synchronous load strobe.
- ld_val  in  NUM_CH*CNT_W  load values; channel i occupies [i*CNT_W +: CNT_W].
- lim  in  NUM_CH*CNT_W  runtime upper limit per channel; legal range is 0..lim inclusive.
- en  in  NUM_CH  per-channel count enable.
- mode  in  NUM_CH*2  per-channel cnt_mode_t (UP, DOWN, HOLD, RSVD).
- wrap  in  NUM_CH  1 = wrap at boundary, 0 = saturate.
- ovf_clr  in  NUM_CH  clears the sticky ovf flag.
- count  out  NUM_CH*CNT_W  registered count.
- at_zero  out  NUM_CH  combinational: en[i] & (count_i == 0).
- at_lim  out  NUM_CH  combinational: en[i] & (count_i == lim_i).
- done  out  NUM_CH  registered one-cycle terminal pulse.
- ovf  out  NUM_CH  sticky wrap/overflow flag.

Behaviour:
- Reset: arst low asynchronously forces count=0, done=0, ovf=0. at_zero and at_lim follow the en inputs.
- Per-channel next-state priority, evaluated each clk:
  1. ld=1: count <= min(ld_val, lim). done is not asserted by a load.
  2. en=1, mode=UP:
     - count<lim: count+1.
     - count==lim: wrap=1 gives 0 and sets ovf; wrap=0 holds lim.
  3. en=1, mode=DOWN:
     - count>0: count-1.
     - count==0: wrap=1 gives lim and sets ovf; wrap=0 holds 0.
  4. en=1, mode=HOLD or RSVD: count unchanged.
  5. en=0: DISABLE_CLEARS ? 0 : hold.
- Limit reduced below the current count: the next enabled UP or DOWN step loads lim, not count±1. No ovf is set.
- lim=0: UP and DOWN both hold at 0 when wrap=0. With wrap=1 the count stays 0 and ovf is set on every step.
- done: registered, asserted for exactly one cycle after a counting step (rule 2 or 3) moves count onto its terminal value:
  - UP: count becomes lim.
  - DOWN: count becomes 0.
  - Holding at a saturated boundary does not re-pulse.
  - A wrap step pulses done only if the wrapped value is itself terminal for the current mode.
- ovf: set on any wrap event. ovf_clr clears it. If set and clear coincide, set wins.
- Latency: count, done, and ovf update one cycle after the inputs. at_zero and at_lim are zero-latency, from the registered count.
- Arithmetic is CNT_W-bit unsigned. No intermediate value exceeds CNT_W+1 bits. Comparisons are unsigned.
- Reset mid-operation: all state is lost, and no done pulse is emitted on reset release.

Decomposition:
- axi_slave_package gains:
  - typedef enum logic [1:0] cnt_mode_t {UP=0, DOWN=1, HOLD=2, RSVD=3}.
  - TRUE/FALSE constants, if not already present.
- One sub-module, up_down_counter_ch: a single-channel slice with CNT_W and DISABLE_CLEARS parameters. The top level instantiates NUM_CH slices in a generate loop and handles vector slicing only.

Test Plan:
- Reset and clear: arst low mid-count (ch0 count=5) -> count=0, done=0, ovf=0 immediately. The cycle after release, count stays 0.
- UP saturate: ch1 lim=3, wrap=0, en=1, UP from 0 for 5 cycles -> count 1,2,3,3,3. done high only in the cycle after count reaches 3. ovf=0.
- UP wrap: ch2 lim=3, wrap=1 -> count 1,2,3,0,1. ovf set after 3->0 and held until ovf_clr. ovf_clr coincident with a new wrap leaves ovf=1.
- DOWN and load priority: ch3 ld=1, ld_val=200, lim=10 -> count=10. Then DOWN -> 9..0, then holds 0. at_zero=1 while holding. done pulses once. ld with en=1 in the same cycle -> load wins.
- Limit shrink and disable: count=7, lim changed to 4, UP step -> count=4, ovf=0. With DISABLE_CLEARS=1, en=0 -> count=0. With DISABLE_CLEARS=0, en=0 -> count holds 4.
- Channel independence: all four channels run different modes simultaneously -> each matches a per-channel reference model every cycle.
